lake_config_loader: RTL and testbench
=====================================

Name: lake_config_loader

Overview:
- Upstream configuration stage for lakespec.
- Accepts 32-bit addressed writes and reads on a simple config bus and assembles them into a CONFIG_MEMORY_SIZE-bit staging register.
- On a commit it transfers the staging register into a double-buffered active register, which drives lakespec's config_memory input.
- Later commits are applied only during flush, so the active configuration never changes while the memory is running.

Parameters:
- CONFIG_MEMORY_SIZE, 512, width of the assembled configuration vector.
- CFG_DATA_WIDTH, 32, config bus data width.
- CFG_ADDR_WIDTH, 32, config bus address width.
- NUM_WORDS (derived, localparam), ceil(CONFIG_MEMORY_SIZE/CFG_DATA_WIDTH); 16 at default.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  same flush as lakespec; gates deferred commits.
- config_config_addr  input  CFG_ADDR_WIDTH  word address.
- config_config_data  input  CFG_DATA_WIDTH  write data.
- config_write  input  1  write strobe, one word per cycle.
- config_read  input  1  read strobe.
- config_rd_data  output  CFG_DATA_WIDTH  readback data.
- config_rd_valid  output  1  pulses for one cycle with readback data.
- config_memory  output  CONFIG_MEMORY_SIZE  active configuration, to lakespec.
- config_loaded  output  1  high once the first commit has landed.
- commit_pending  output  1  a commit has been requested and is not yet applied.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. Decided.
- Reset values: staging=0, config_memory=0, config_loaded=0, commit_pending=0, config_rd_data=0, config_rd_valid=0. All apply immediately, with no clock edge required.
- Address map:
  - 0..NUM_WORDS-1: staging words. Word k maps to bits [32k+31:32k].
  - NUM_WORDS: CTRL. Writing bit0=1 requests a commit; other bits are ignored. Reads as 0.
  - NUM_WORDS+1: STATUS, read-only. bit0=commit_pending, bit1=config_loaded.
  - Any other address: writes are ignored and reads return 0.
- Partial last word: bits at or above CONFIG_MEMORY_SIZE are discarded on write and read back as 0.
- Write: takes effect at the edge where config_write=1.
- Read: registered, 1-cycle latency. config_rd_valid=1 and config_rd_data are valid on the cycle after config_read. config_rd_data holds its value afterwards. config_rd_valid is 0 when no read occurred.
- Simultaneous read and write to the same address: the read returns the pre-write value.
- Commit state machine, states IDLE and PENDING:
  - IDLE -> PENDING on a CTRL write with bit0=1.
  - PENDING -> IDLE at the first edge where (flush==1 || config_loaded==0). At that edge config_memory <= staging and config_loaded <= 1.
  - Net effect: the first commit lands one edge after the CTRL write. Later commits wait for flush.
  - A CTRL commit write while PENDING is a no-op; the state stays PENDING.
- A staging write on the same edge as a transfer: the active register captures the pre-write staging value. The new word remains only in staging.
- Between commits, config_memory is stable regardless of bus activity.
- config_loaded never clears except on reset.
- Reset mid-operation: a pending commit is discarded and both registers are zeroed.

Decomposition:
- Package lake_cfg_pkg holds:
  - function cfg_num_words(size, width).
  - localparams CFG_CTRL_OFS = 0 and CFG_STATUS_OFS = 1, relative to NUM_WORDS.
  - STATUS bit indices.
  - Commit state enum {CFG_IDLE, CFG_PENDING}.
- One natural sub-module, lake_cfg_readback: a registered read mux over staging words plus STATUS, producing config_rd_data and config_rd_valid.
- The staging register, active register and FSM stay in the top module.

Test Plan:
1. Reset: assert rst_n=0 with no clock -> all outputs 0. Read STATUS after release -> 0x0.
2. First load: write words 0..15 with 0xA5A50000+i, then CTRL=1 -> next edge config_memory[31:0]=0xA5A50000, [511:480]=0xA5A5000F, config_loaded=1, commit_pending=0.
3. Deferred commit:
   - Write word 0=0x12345678, then CTRL=1 with flush=0 -> config_memory[31:0] stays 0xA5A50000 for 10 cycles; STATUS reads 0x3.
   - Raise flush -> next edge config_memory[31:0]=0x12345678, STATUS=0x2.
4. Readback:
   - Read addr 3 -> the following cycle rd_valid=1, rd_data=0xA5A50003.
   - Read addr 20 -> rd_data=0.
   - Read and write addr 5 (data 0xDEAD) in the same cycle -> rd_data=0xA5A50005; a later read returns 0xDEAD.
5. CONFIG_MEMORY_SIZE=40 (NUM_WORDS=2):
   - Write word 1=0xFFFFFFFF and commit -> config_memory[39:32]=0xFF; readback of word 1=0x000000FF.
   - Write to addr 5 -> no state change.
6. Reset mid-commit: with PENDING and config_loaded=1, pulse rst_n low -> config_memory=0, commit_pending=0, config_loaded=0 immediately.

Source files
------------

// File: rtl/lake_cfg_pkg.sv
// Shared constants, address-map offsets and commit-state encoding for the
// lakespec configuration loader.
package lake_cfg_pkg;

    localparam int CFG_CTRL_OFS         = 0;
    localparam int CFG_STATUS_OFS       = 1;
    localparam int CFG_STAT_PENDING_BIT = 0;
    localparam int CFG_STAT_LOADED_BIT  = 1;

    typedef enum logic {
        CFG_IDLE    = 1'b0,
        CFG_PENDING = 1'b1
    } cfg_state_e;

    function automatic int cfg_num_words(input int size, input int width);
        return (size + width - 1) / width;
    endfunction

endpackage

// File: rtl/lake_cfg_readback.sv
// Registered read mux over the staging words and the STATUS register.
// One cycle of latency; read data holds until the next read.
module lake_cfg_readback
    import lake_cfg_pkg::*;
#(
    parameter int NUM_WORDS      = 16,
    parameter int CFG_DATA_WIDTH = 32,
    parameter int CFG_ADDR_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                rd_en,
    input  logic [CFG_ADDR_WIDTH-1:0]           rd_addr,
    input  logic [NUM_WORDS*CFG_DATA_WIDTH-1:0] staging,
    input  logic                                pending,
    input  logic                                loaded,
    output logic [CFG_DATA_WIDTH-1:0]           rd_data,
    output logic                                rd_valid
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CFG_ADDR_WIDTH-1:0] STATUS_ADDR =
        CFG_ADDR_WIDTH'(NUM_WORDS + CFG_STATUS_OFS);

    logic [CFG_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                      rd_valid_q, rd_valid_d;

    // CTRL and unmapped addresses fall through to zero.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en;
        if (rd_en) begin
            rd_data_d = '0;
            if (rd_addr < CFG_ADDR_WIDTH'(NUM_WORDS)) begin
                rd_data_d = staging[int'(rd_addr[IDX_W-1:0])*CFG_DATA_WIDTH +: CFG_DATA_WIDTH];
            end else if (rd_addr == STATUS_ADDR) begin
                rd_data_d[CFG_STAT_PENDING_BIT] = pending;
                rd_data_d[CFG_STAT_LOADED_BIT]  = loaded;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: rtl/lake_config_loader.sv
// Config-bus front end for lakespec: word writes assemble a staging vector,
// CTRL commits copy it into the active register (after the first, only on flush).
module lake_config_loader
    import lake_cfg_pkg::*;
#(
    parameter int CONFIG_MEMORY_SIZE = 512,
    parameter int CFG_DATA_WIDTH     = 32,
    parameter int CFG_ADDR_WIDTH     = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [CFG_ADDR_WIDTH-1:0]     config_config_addr,
    input  logic [CFG_DATA_WIDTH-1:0]     config_config_data,
    input  logic                          config_write,
    input  logic                          config_read,
    output logic [CFG_DATA_WIDTH-1:0]     config_rd_data,
    output logic                          config_rd_valid,
    output logic [CONFIG_MEMORY_SIZE-1:0] config_memory,
    output logic                          config_loaded,
    output logic                          commit_pending
);

    localparam int NUM_WORDS = cfg_num_words(CONFIG_MEMORY_SIZE, CFG_DATA_WIDTH);
    localparam int PAD_W     = NUM_WORDS * CFG_DATA_WIDTH;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    // Bits of the padded last word beyond CONFIG_MEMORY_SIZE are never stored.
    localparam logic [PAD_W-1:0] VALID_MASK = {PAD_W{1'b1}} >> (PAD_W - CONFIG_MEMORY_SIZE);
    localparam logic [CFG_ADDR_WIDTH-1:0] CTRL_ADDR =
        CFG_ADDR_WIDTH'(NUM_WORDS + CFG_CTRL_OFS);

    logic [PAD_W-1:0]              staging_q, staging_d;
    logic [CONFIG_MEMORY_SIZE-1:0] active_q, active_d;
    logic                          loaded_q, loaded_d;
    cfg_state_e                    state_q, state_d;

    logic             stage_hit;
    logic             commit_req;
    logic [IDX_W-1:0] wr_idx;

    assign stage_hit  = config_config_addr < CFG_ADDR_WIDTH'(NUM_WORDS);
    assign commit_req = config_write && (config_config_addr == CTRL_ADDR) && config_config_data[0];
    assign wr_idx     = config_config_addr[IDX_W-1:0];

    always_comb begin
        staging_d = staging_q;
        active_d  = active_q;
        loaded_d  = loaded_q;
        state_d   = state_q;
        if (config_write && stage_hit) begin
            staging_d[int'(wr_idx)*CFG_DATA_WIDTH +: CFG_DATA_WIDTH] = config_config_data;
            staging_d = staging_d & VALID_MASK;
        end
        // Transfer uses staging_q, so a same-edge word write stays in staging only.
        case (state_q)
            CFG_IDLE: if (commit_req) state_d = CFG_PENDING;
            CFG_PENDING: begin
                if (flush || !loaded_q) begin
                    active_d = staging_q[CONFIG_MEMORY_SIZE-1:0];
                    loaded_d = 1'b1;
                    state_d  = CFG_IDLE;
                end
            end
            default: state_d = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging_q <= '0;
            active_q  <= '0;
            loaded_q  <= 1'b0;
            state_q   <= CFG_IDLE;
        end else begin
            staging_q <= staging_d;
            active_q  <= active_d;
            loaded_q  <= loaded_d;
            state_q   <= state_d;
        end
    end

    assign config_memory  = active_q;
    assign config_loaded  = loaded_q;
    assign commit_pending = (state_q == CFG_PENDING);

    lake_cfg_readback #(
        .NUM_WORDS      (NUM_WORDS),
        .CFG_DATA_WIDTH (CFG_DATA_WIDTH),
        .CFG_ADDR_WIDTH (CFG_ADDR_WIDTH)
    ) u_readback (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (config_read),
        .rd_addr  (config_config_addr),
        .staging  (staging_q),
        .pending  (commit_pending),
        .loaded   (loaded_q),
        .rd_data  (config_rd_data),
        .rd_valid (config_rd_valid)
    );

endmodule

// File: tb/tb_lake_config_loader.sv
// Directed bench for lake_config_loader: a default 512-bit instance and a
// 40-bit instance that exercises the partial last word.
module tb_lake_config_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;

    logic [31:0]  addr = '0, wdata = '0, rd_data;
    logic         wr = 1'b0, rd = 1'b0, rd_valid, loaded, pending;
    logic [511:0] mem;

    logic [31:0]  s_addr = '0, s_wdata = '0, s_rd_data;
    logic         s_wr = 1'b0, s_rd = 1'b0, s_rd_valid, s_loaded, s_pending;
    logic [39:0]  s_mem;

    int total = 0;
    int bad   = 0;

    logic [511:0] exp_mem;
    logic [31:0]  d;
    logic         v;

    always #5 clk = ~clk;

    lake_config_loader u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .config_config_addr(addr), .config_config_data(wdata),
        .config_write(wr), .config_read(rd),
        .config_rd_data(rd_data), .config_rd_valid(rd_valid),
        .config_memory(mem), .config_loaded(loaded), .commit_pending(pending)
    );

    lake_config_loader #(.CONFIG_MEMORY_SIZE(40)) u_small (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .config_config_addr(s_addr), .config_config_data(s_wdata),
        .config_write(s_wr), .config_read(s_rd),
        .config_rd_data(s_rd_data), .config_rd_valid(s_rd_valid),
        .config_memory(s_mem), .config_loaded(s_loaded), .commit_pending(s_pending)
    );

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] dat);
        @(negedge clk);
        addr = a; wdata = dat; wr = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] dat, output logic vld);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        dat = rd_data; vld = rd_valid;
    endtask

    task automatic s_bus_wr(input logic [31:0] a, input logic [31:0] dat);
        @(negedge clk);
        s_addr = a; s_wdata = dat; s_wr = 1'b1;
        @(posedge clk); #1;
        s_wr = 1'b0;
    endtask

    task automatic s_bus_rd(input logic [31:0] a, output logic [31:0] dat);
        @(negedge clk);
        s_addr = a; s_rd = 1'b1;
        @(posedge clk); #1;
        s_rd = 1'b0;
        dat = s_rd_data;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++; if (mem !== 512'h0) begin bad++; $display("FAIL reset_mem got %h want 0", mem[31:0]); end
        total++; if ({loaded, pending, rd_valid} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b want 000", {loaded, pending, rd_valid}); end
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        total++; if ({s_mem, s_loaded, s_pending} !== 42'h0) begin bad++; $display("FAIL reset_small got %h want 0", {s_mem, s_loaded, s_pending}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_rd(32'd17, d, v);
        total++; if ({v, d} !== {1'b1, 32'h0}) begin bad++; $display("FAIL reset_status got v=%b d=%h want v=1 d=0", v, d); end
    endtask

    task automatic test_first_load();
        for (int i = 0; i < 16; i++) begin
            bus_wr(i, 32'hA5A5_0000 + i);
            exp_mem[i*32 +: 32] = 32'hA5A5_0000 + i;
        end
        bus_wr(32'd16, 32'h1);
        total++; if ({pending, mem[31:0]} !== {1'b1, 32'h0}) begin bad++; $display("FAIL load_pending got p=%b m=%h want p=1 m=0", pending, mem[31:0]); end
        @(posedge clk); #1;
        total++; if (mem[31:0] !== 32'hA5A5_0000) begin bad++; $display("FAIL load_word0 got %h want a5a50000", mem[31:0]); end
        total++; if (mem[511:480] !== 32'hA5A5_000F) begin bad++; $display("FAIL load_word15 got %h want a5a5000f", mem[511:480]); end
        total++; if (mem !== exp_mem) begin bad++; $display("FAIL load_full got %h want %h", mem[255:0], exp_mem[255:0]); end
        total++; if ({loaded, pending} !== 2'b10) begin bad++; $display("FAIL load_flags got %b want 10", {loaded, pending}); end
    endtask

    task automatic test_deferred();
        flush = 1'b0;
        bus_wr(32'd0, 32'h1234_5678);
        bus_wr(32'd16, 32'h1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total++; if (mem[31:0] !== 32'hA5A5_0000) begin bad++; $display("FAIL defer_hold cyc%0d got %h want a5a50000", c, mem[31:0]); end
        end
        bus_rd(32'd17, d, v);
        total++; if (d !== 32'h3) begin bad++; $display("FAIL defer_status got %h want 3", d); end
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++; if (mem[31:0] !== 32'h1234_5678) begin bad++; $display("FAIL defer_apply got %h want 12345678", mem[31:0]); end
        total++; if (mem[511:32] !== exp_mem[511:32]) begin bad++; $display("FAIL defer_upper got %h want %h", mem[63:32], exp_mem[63:32]); end
        bus_rd(32'd17, d, v);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL defer_status2 got %h want 2", d); end
        exp_mem[31:0] = 32'h1234_5678;
    endtask

    task automatic test_readback();
        bus_rd(32'd3, d, v);
        total++; if ({v, d} !== {1'b1, 32'hA5A5_0003}) begin bad++; $display("FAIL rd_addr3 got v=%b d=%h want v=1 d=a5a50003", v, d); end
        @(posedge clk); #1;
        total++; if ({rd_valid, rd_data} !== {1'b0, 32'hA5A5_0003}) begin bad++; $display("FAIL rd_hold got v=%b d=%h want v=0 d=a5a50003", rd_valid, rd_data); end
        bus_rd(32'd20, d, v);
        total++; if ({v, d} !== {1'b1, 32'h0}) begin bad++; $display("FAIL rd_unmapped got v=%b d=%h want v=1 d=0", v, d); end
        bus_rd(32'd2, d, v);
        bus_rd(32'd16, d, v);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rd_ctrl got %h want 0", d); end
        @(negedge clk);
        addr = 32'd5; wdata = 32'h0000_DEAD; wr = 1'b1; rd = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0;
        total++; if (rd_data !== 32'hA5A5_0005) begin bad++; $display("FAIL rd_raw got %h want a5a50005", rd_data); end
        bus_rd(32'd5, d, v);
        total++; if (d !== 32'h0000_DEAD) begin bad++; $display("FAIL rd_after_wr got %h want 0000dead", d); end
        total++; if (mem !== exp_mem) begin bad++; $display("FAIL rd_mem_stable got %h want %h", mem[191:160], exp_mem[191:160]); end
    endtask

    task automatic test_small();
        s_bus_wr(32'd1, 32'hFFFF_FFFF);
        s_bus_wr(32'd2, 32'h1);
        total++; if (s_pending !== 1'b1) begin bad++; $display("FAIL small_pending got %b want 1", s_pending); end
        @(posedge clk); #1;
        total++; if (s_mem !== 40'hFF_0000_0000) begin bad++; $display("FAIL small_mem got %h want ff00000000", s_mem); end
        total++; if ({s_loaded, s_pending} !== 2'b10) begin bad++; $display("FAIL small_flags got %b want 10", {s_loaded, s_pending}); end
        s_bus_rd(32'd1, d);
        total++; if (d !== 32'h0000_00FF) begin bad++; $display("FAIL small_rd1 got %h want 000000ff", d); end
        s_bus_wr(32'd5, 32'h0000_ABCD);
        total++; if (s_mem !== 40'hFF_0000_0000) begin bad++; $display("FAIL small_oob_mem got %h want ff00000000", s_mem); end
        s_bus_rd(32'd0, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL small_oob_w0 got %h want 0", d); end
        s_bus_rd(32'd1, d);
        total++; if (d !== 32'h0000_00FF) begin bad++; $display("FAIL small_oob_w1 got %h want 000000ff", d); end
        s_bus_rd(32'd3, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL small_status got %h want 2", d); end
    endtask

    task automatic test_reset_mid();
        flush = 1'b0;
        bus_wr(32'd16, 32'h1);
        total++; if ({loaded, pending} !== 2'b11) begin bad++; $display("FAIL mid_pre got %b want 11", {loaded, pending}); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (mem !== 512'h0) begin bad++; $display("FAIL mid_mem got %h want 0", mem[31:0]); end
        total++; if ({loaded, pending} !== 2'b00) begin bad++; $display("FAIL mid_flags got %b want 00", {loaded, pending}); end
        total++; if (s_mem !== 40'h0) begin bad++; $display("FAIL mid_small got %h want 0", s_mem); end
        @(negedge clk); rst_n = 1'b1;
        bus_rd(32'd0, d, v);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_staging got %h want 0", d); end
        @(posedge clk); #1;
        total++; if ({loaded, pending, mem[31:0]} !== 34'h0) begin bad++; $display("FAIL mid_no_commit got l=%b p=%b m=%h want 0", loaded, pending, mem[31:0]); end
    endtask

    initial begin
        exp_mem = '0;
        test_reset();
        test_first_load();
        test_deferred();
        test_readback();
        test_small();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
